// File: rtl/free_id_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : free_id_arbiter_pkg
// Purpose  : Shared constants and helpers for the free-ID arbiter. It covers
//            the port-index width, the default counter width, and the offset
//            of a slice inside a packed per-port bus.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package free_id_arbiter_pkg;

    // Default occupancy-counter width. It must satisfy 2**width > pool size.
    localparam int unsigned c_DEF_CNT_WIDTH = 6;

    // Width of an index into n ports. The result is never narrower than 1 bit.
    function automatic int unsigned f_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB position of element idx in a packed bus of width-bit elements.
    function automatic int unsigned f_slice_lsb(input int unsigned idx,
                                                input int unsigned width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/free_id_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : free_id_arbiter_rr
// Purpose  : Round-robin arbiter. It grants the first request found at or
//            after the pointer, with zero latency. After each grant, the
//            pointer moves one past the winner.
// Ports    : clk, reset   - clock, synchronous active-high reset
//            i_req        - request vector
//            i_en         - arbitration enable; no grant while low
//            o_gnt        - one-hot grant
//            o_idx        - index of the granted requester
//            o_any        - a grant is issued this cycle
//            o_ptr        - current round-robin pointer
// Revision : 1.0 - initial release
// ============================================================================
module free_id_arbiter_rr #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     i_req,
    input  logic             i_en,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any,
    output logic [IDX_W-1:0] o_ptr
);

    logic [IDX_W-1:0] r_ptr;
    // One extra bit holds ptr+k before it wraps back below N.
    logic [IDX_W:0]   w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 0; k < int'(N); k++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(N)) begin
                w_cand = w_cand - (IDX_W+1)'(N);
            end
            if (i_en && !o_any && i_req[w_cand[IDX_W-1:0]]) begin
                o_any = 1'b1;
                o_idx = w_cand[IDX_W-1:0];
            end
        end
        if (o_any) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (o_any) begin
            r_ptr <= (o_idx == IDX_W'(N-1)) ? '0 : o_idx + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/free_id_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : free_id_arbiter
// Purpose  : Shares one FWFT free-buffer-ID FIFO among NUM_PORTS requesters.
//            Allocations pop the free list and releases push it. Each side
//            is arbitrated round-robin on its own. The block enforces a
//            per-port quota, tracks total and per-port occupancy, and flags
//            over-release with a sticky per-port bit.
// Ports    : clk, reset                        - clock, sync active-high reset
//            alloc_req/alloc_gnt/alloc_id      - allocation handshake
//            release_valid/release_id/release_ready - release handshake
//            fifo_empty_n/fifo_dout/fifo_read/fifo_read_ce    - free-list pop
//            fifo_full_n/fifo_din/fifo_write/fifo_write_ce    - free-list push
//            in_use, port_in_use               - occupancy counters
//            err_underflow                     - sticky over-release flags
// Revision : 1.0 - initial release
// ============================================================================
module free_id_arbiter
    import free_id_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ID_WIDTH  = 5,
    parameter int unsigned NUM_IDS   = 32,
    parameter int unsigned QUOTA     = 8,
    parameter int unsigned CNT_WIDTH = c_DEF_CNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           alloc_req,
    output logic [NUM_PORTS-1:0]           alloc_gnt,
    output logic [ID_WIDTH-1:0]            alloc_id,
    input  logic [NUM_PORTS-1:0]           release_valid,
    input  logic [NUM_PORTS*ID_WIDTH-1:0]  release_id,
    output logic [NUM_PORTS-1:0]           release_ready,
    input  logic                           fifo_empty_n,
    input  logic [ID_WIDTH-1:0]            fifo_dout,
    output logic                           fifo_read,
    output logic                           fifo_read_ce,
    input  logic                           fifo_full_n,
    output logic [ID_WIDTH-1:0]            fifo_din,
    output logic                           fifo_write,
    output logic                           fifo_write_ce,
    output logic [CNT_WIDTH-1:0]           in_use,
    output logic [NUM_PORTS*CNT_WIDTH-1:0] port_in_use,
    output logic [NUM_PORTS-1:0]           err_underflow
);

    localparam int unsigned c_IDX_W   = f_idx_width(NUM_PORTS);
    localparam logic [CNT_WIDTH-1:0] c_QUOTA   = CNT_WIDTH'(QUOTA);
    localparam logic [CNT_WIDTH-1:0] c_NUM_IDS = CNT_WIDTH'(NUM_IDS);

    logic [NUM_PORTS-1:0] w_elig;
    logic [NUM_PORTS-1:0] w_agnt;
    logic [NUM_PORTS-1:0] w_rrdy;
    logic [c_IDX_W-1:0]   w_aidx;
    logic [c_IDX_W-1:0]   w_ridx;
    logic [c_IDX_W-1:0]   w_aptr;
    logic [c_IDX_W-1:0]   w_rptr;
    logic                 w_aany;
    logic                 w_rany;
    logic [CNT_WIDTH-1:0] r_in_use;

    // Both arbiters are disabled during reset. This blocks all handshakes
    // while the free list re-initializes.
    free_id_arbiter_rr #(.N(NUM_PORTS), .IDX_W(c_IDX_W)) u_alloc_rr (
        .clk   (clk),
        .reset (reset),
        .i_req (w_elig),
        .i_en  (fifo_empty_n & ~reset),
        .o_gnt (w_agnt),
        .o_idx (w_aidx),
        .o_any (w_aany),
        .o_ptr (w_aptr)
    );

    free_id_arbiter_rr #(.N(NUM_PORTS), .IDX_W(c_IDX_W)) u_release_rr (
        .clk   (clk),
        .reset (reset),
        .i_req (release_valid),
        .i_en  (fifo_full_n & ~reset),
        .o_gnt (w_rrdy),
        .o_idx (w_ridx),
        .o_any (w_rany),
        .o_ptr (w_rptr)
    );

    assign alloc_gnt     = w_agnt;
    assign alloc_id      = fifo_dout;
    assign fifo_read     = w_aany;
    assign release_ready = w_rrdy;
    assign fifo_din      = release_id[f_slice_lsb(32'(w_ridx), ID_WIDTH) +: ID_WIDTH];
    assign fifo_write    = w_rany;
    assign fifo_read_ce  = ~reset;
    assign fifo_write_ce = ~reset;

    for (genvar gi = 0; gi < int'(NUM_PORTS); gi++) begin : g_port
        logic [CNT_WIDTH-1:0] r_cnt;
        logic                 r_err;
        logic                 w_a;
        logic                 w_r;

        assign w_a = w_agnt[gi];
        assign w_r = w_rrdy[gi];
        // Eligibility uses the registered count. A release in the same
        // cycle does not free quota until the next edge.
        assign w_elig[gi] = alloc_req[gi] && (r_cnt < c_QUOTA);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
                r_err <= 1'b0;
            end else begin
                if (w_r && (r_cnt == '0)) begin
                    r_err <= 1'b1;
                end
                if (w_a && !w_r) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (w_r && !w_a && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end

        assign port_in_use[f_slice_lsb(gi, CNT_WIDTH) +: CNT_WIDTH] = r_cnt;
        assign err_underflow[gi] = r_err;
    end

    // The total can never legitimately exceed the pool size. On underflow,
    // the total saturates at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_use <= '0;
        end else if (w_aany && !w_rany && (r_in_use != c_NUM_IDS)) begin
            r_in_use <= r_in_use + 1'b1;
        end else if (w_rany && !w_aany && (r_in_use != '0)) begin
            r_in_use <= r_in_use - 1'b1;
        end
    end

    assign in_use = r_in_use;

    // The pointers are observable only through grant order.
    logic w_unused;
    assign w_unused = ^{w_aptr, w_rptr};

endmodule
`default_nettype wire

// File: tb/tb_free_id_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_free_id_arbiter
// Purpose  : Self-checking bench for free_id_arbiter with QUOTA=2. It runs
//            hand sequences, a vector table and a randomized phase. All of
//            them are checked against a behavioural model of occupancy and
//            round-robin order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_free_id_arbiter;

    localparam int NP = 4;
    localparam int IW = 5;
    localparam int NI = 32;
    localparam int Q  = 2;
    localparam int CW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic [NP-1:0]      alloc_req, release_valid;
    logic [NP*IW-1:0]   release_id;
    logic               fifo_empty_n, fifo_full_n;
    logic [IW-1:0]      fifo_dout;
    logic [NP-1:0]      alloc_gnt, release_ready, err_underflow;
    logic [IW-1:0]      alloc_id, fifo_din;
    logic               fifo_read, fifo_read_ce, fifo_write, fifo_write_ce;
    logic [CW-1:0]      in_use;
    logic [NP*CW-1:0]   port_in_use;

    free_id_arbiter #(
        .NUM_PORTS(NP), .ID_WIDTH(IW), .NUM_IDS(NI), .QUOTA(Q), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_id(alloc_id),
        .release_valid(release_valid), .release_id(release_id),
        .release_ready(release_ready),
        .fifo_empty_n(fifo_empty_n), .fifo_dout(fifo_dout),
        .fifo_read(fifo_read), .fifo_read_ce(fifo_read_ce),
        .fifo_full_n(fifo_full_n), .fifo_din(fifo_din),
        .fifo_write(fifo_write), .fifo_write_ce(fifo_write_ce),
        .in_use(in_use), .port_in_use(port_in_use),
        .err_underflow(err_underflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: held counts, total, pointers, sticky errors
    int m_cnt[NP];
    int m_inuse;
    int m_aptr, m_rptr;
    bit m_err[NP];
    int e_ga, e_gr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NP-1:0] v, input int ptr, input bit en);
        if (!en) return -1;
        for (int k = 0; k < NP; k++) begin
            if (v[(ptr + k) % NP]) return (ptr + k) % NP;
        end
        return -1;
    endfunction

    task automatic drive(input logic rst, input logic [NP-1:0] req, input logic [NP-1:0] rv,
                         input logic [NP*IW-1:0] rid, input logic en_n,
                         input logic [IW-1:0] dout, input logic fn);
        reset = rst; alloc_req = req; release_valid = rv; release_id = rid;
        fifo_empty_n = en_n; fifo_dout = dout; fifo_full_n = fn;
    endtask

    // Combinational checks, made mid-cycle after the inputs settle.
    task automatic pre();
        logic [NP-1:0] el;
        logic [NP-1:0] eg, er;
        #2;
        for (int p = 0; p < NP; p++) el[p] = alloc_req[p] && (m_cnt[p] < Q);
        e_ga = reset ? -1 : pick(el, m_aptr, fifo_empty_n);
        e_gr = reset ? -1 : pick(release_valid, m_rptr, fifo_full_n);
        eg = (e_ga >= 0) ? (NP'(1) << e_ga) : '0;
        er = (e_gr >= 0) ? (NP'(1) << e_gr) : '0;
        chk("alloc_gnt", 64'(alloc_gnt), 64'(eg));
        chk("release_ready", 64'(release_ready), 64'(er));
        chk("fifo_read", 64'(fifo_read), 64'(e_ga >= 0));
        chk("fifo_write", 64'(fifo_write), 64'(e_gr >= 0));
        chk("fifo_read_ce", 64'(fifo_read_ce), 64'(!reset));
        chk("fifo_write_ce", 64'(fifo_write_ce), 64'(!reset));
        if (e_ga >= 0) chk("alloc_id", 64'(alloc_id), 64'(fifo_dout));
        if (e_gr >= 0) chk("fifo_din", 64'(fifo_din), 64'(release_id[e_gr*IW +: IW]));
    endtask

    // Clock edge, model update, then registered-state checks.
    task automatic post();
        @(posedge clk);
        if (reset) begin
            for (int p = 0; p < NP; p++) begin m_cnt[p] = 0; m_err[p] = 0; end
            m_inuse = 0; m_aptr = 0; m_rptr = 0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                bit a, r;
                a = (p == e_ga);
                r = (p == e_gr);
                if (r && m_cnt[p] == 0) m_err[p] = 1;
                if (a && !r) m_cnt[p]++;
                else if (r && !a && m_cnt[p] > 0) m_cnt[p]--;
            end
            if (e_ga >= 0 && e_gr < 0 && m_inuse < NI) m_inuse++;
            else if (e_gr >= 0 && e_ga < 0 && m_inuse > 0) m_inuse--;
            if (e_ga >= 0) m_aptr = (e_ga + 1) % NP;
            if (e_gr >= 0) m_rptr = (e_gr + 1) % NP;
        end
        #1;
        chk("in_use", 64'(in_use), 64'(m_inuse));
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("port_in_use[%0d]", p), 64'(port_in_use[p*CW +: CW]), 64'(m_cnt[p]));
            chk($sformatf("err_underflow[%0d]", p), 64'(err_underflow[p]), 64'(m_err[p]));
        end
    endtask

    typedef struct {
        logic          rst;
        logic [NP-1:0] req, rv;
        logic [NP*IW-1:0] rid;
        logic          en_n;
        logic [IW-1:0] dout;
        logic          full_n;
        logic [NP-1:0] x_gnt;
        logic [IW-1:0] x_id;
        logic [NP-1:0] x_rdy;
        int            x_inuse;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Round-robin vectors, then quota vectors (QUOTA=2, port1 releases ID 7)
        tbl.push_back('{1'b1, 4'h0, 4'h0, 20'h0, 1'b0, 5'd0,  1'b1, 4'h0, 5'd0,  4'h0, 0});
        tbl.push_back('{1'b0, 4'hF, 4'h0, 20'h0, 1'b1, 5'd0,  1'b1, 4'h1, 5'd0,  4'h0, 1});
        tbl.push_back('{1'b0, 4'hF, 4'h0, 20'h0, 1'b1, 5'd1,  1'b1, 4'h2, 5'd1,  4'h0, 2});
        tbl.push_back('{1'b0, 4'hF, 4'h0, 20'h0, 1'b1, 5'd2,  1'b1, 4'h4, 5'd2,  4'h0, 3});
        tbl.push_back('{1'b0, 4'hF, 4'h0, 20'h0, 1'b1, 5'd3,  1'b1, 4'h8, 5'd3,  4'h0, 4});
        tbl.push_back('{1'b0, 4'hF, 4'h0, 20'h0, 1'b1, 5'd4,  1'b1, 4'h1, 5'd4,  4'h0, 5});
        tbl.push_back('{1'b1, 4'h0, 4'h0, 20'h0, 1'b1, 5'd0,  1'b1, 4'h0, 5'd0,  4'h0, 0});
        tbl.push_back('{1'b0, 4'h2, 4'h0, 20'h0, 1'b1, 5'd10, 1'b1, 4'h2, 5'd10, 4'h0, 1});
        tbl.push_back('{1'b0, 4'h2, 4'h0, 20'h0, 1'b1, 5'd11, 1'b1, 4'h2, 5'd11, 4'h0, 2});
        tbl.push_back('{1'b0, 4'h2, 4'h0, 20'h0, 1'b1, 5'd12, 1'b1, 4'h0, 5'd0,  4'h0, 2});
        tbl.push_back('{1'b0, 4'h2, 4'h2, 20'h000E0, 1'b1, 5'd12, 1'b1, 4'h0, 5'd0, 4'h2, 1});
        tbl.push_back('{1'b0, 4'h2, 4'h0, 20'h0, 1'b1, 5'd12, 1'b1, 4'h2, 5'd12, 4'h0, 2});

        drive(1'b1, '0, '0, '0, 1'b0, '0, 1'b1);
        @(posedge clk); #1;

        // Init: the free list reports empty for 32 cycles, and port 0 waits.
        pre(); post();
        for (int c = 0; c < 32; c++) begin
            drive(1'b0, 4'h1, '0, '0, 1'b0, 5'd0, 1'b1);
            pre();
            chk("init_no_gnt", 64'(alloc_gnt), 64'(0));
            post();
        end
        drive(1'b0, 4'h1, '0, '0, 1'b1, 5'd0, 1'b1);
        pre();
        chk("init_first_gnt", 64'(alloc_gnt), 64'h1);
        chk("init_first_id", 64'(alloc_id), 64'(0));
        post();
        chk("init_in_use", 64'(in_use), 64'(1));

        // Table-driven vectors
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].rv, tbl[i].rid, tbl[i].en_n,
                  tbl[i].dout, tbl[i].full_n);
            pre();
            chk($sformatf("vec%0d_gnt", i), 64'(alloc_gnt), 64'(tbl[i].x_gnt));
            if (tbl[i].x_gnt != '0) chk($sformatf("vec%0d_id", i), 64'(alloc_id), 64'(tbl[i].x_id));
            chk($sformatf("vec%0d_rdy", i), 64'(release_ready), 64'(tbl[i].x_rdy));
            post();
            chk($sformatf("vec%0d_in_use", i), 64'(in_use), 64'(tbl[i].x_inuse));
        end

        // Simultaneous alloc and release on port 2
        drive(1'b0, 4'h4, '0, '0, 1'b1, 5'd20, 1'b1);
        pre(); post();
        drive(1'b0, 4'h4, 4'h4, 20'(5'd20) << 10, 1'b1, 5'd21, 1'b1);
        pre();
        chk("simul_read", 64'(fifo_read), 64'(1));
        chk("simul_write", 64'(fifo_write), 64'(1));
        chk("simul_din", 64'(fifo_din), 64'(20));
        post();
        chk("simul_port2", 64'(port_in_use[2*CW +: CW]), 64'(1));
        chk("simul_in_use", 64'(in_use), 64'(3));

        // Full free list blocks release; then port 3 over-releases.
        drive(1'b1, '0, '0, '0, 1'b1, '0, 1'b1);
        pre(); post();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, '0, 4'h8, 20'(5'd9) << 15, 1'b1, '0, 1'b0);
            pre();
            chk("full_no_rdy", 64'(release_ready), 64'(0));
            post();
        end
        drive(1'b0, '0, 4'h8, 20'(5'd9) << 15, 1'b1, '0, 1'b1);
        pre();
        chk("uf_rdy", 64'(release_ready), 64'h8);
        chk("uf_write", 64'(fifo_write), 64'(1));
        post();
        chk("uf_err", 64'(err_underflow), 64'h8);
        chk("uf_in_use", 64'(in_use), 64'(0));
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, '0, '0, '0, 1'b1, '0, 1'b1);
            pre(); post();
            chk("uf_sticky", 64'(err_underflow[3]), 64'(1));
        end

        // Reset mid-run with five IDs outstanding
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'hF, '0, '0, 1'b1, IW'(c + 1), 1'b1);
            pre(); post();
        end
        chk("midrst_before", 64'(in_use), 64'(5));
        drive(1'b1, 4'hF, 4'hF, '0, 1'b1, '0, 1'b1);
        pre();
        chk("midrst_gnt", 64'(alloc_gnt), 64'(0));
        chk("midrst_rdy", 64'(release_ready), 64'(0));
        post();
        chk("midrst_in_use", 64'(in_use), 64'(0));
        chk("midrst_ports", 64'(port_in_use), 64'(0));
        chk("midrst_err", 64'(err_underflow), 64'(0));
        drive(1'b0, 4'hF, 4'hF, '0, 1'b1, 5'd3, 1'b1);
        pre();
        chk("midrst_aptr0", 64'(alloc_gnt), 64'h1);
        chk("midrst_rptr0", 64'(release_ready), 64'h1);
        post();

        // Randomized phase against the model
        for (int c = 0; c < 400; c++) begin
            logic [NP-1:0] rv;
            for (int p = 0; p < NP; p++) rv[p] = ($urandom_range(3) == 0);
            drive(($urandom_range(49) == 0), NP'($urandom), rv, (NP*IW)'($urandom),
                  ($urandom_range(4) != 0), IW'($urandom), ($urandom_range(4) != 0));
            pre(); post();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
